// File: rtl/noise_variance_averager_if.sv
// Result handshake between the noise averager and the denoising stage.
interface noise_variance_averager_if #(
  parameter int VAR_WIDTH = 16
) ();
  logic [VAR_WIDTH-1:0] noise_estimate;
  logic                 noise_valid;
  logic                 acc_saturated;
  logic                 noise_ready;

  modport master (output noise_estimate, output noise_valid, output acc_saturated, input noise_ready);
  modport slave  (input noise_estimate, input noise_valid, input acc_saturated, output noise_ready);
endinterface

// File: rtl/noise_variance_averager.sv
// Sums per-block variances over a frame, divides by block count with a
// restoring divider and hands the frame noise estimate downstream.
module noise_variance_averager #(
  parameter int VAR_WIDTH = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_of_frame,
  input  logic                 noise_mean_en,
  input  logic [VAR_WIDTH-1:0] variance_in,
  input  logic [31:0]          blocks_per_frame,
  noise_variance_averager_if.master out_if,
  output logic                 busy
);
  // Remainder must hold a shifted value compared against a 32b count.
  localparam int RW  = ((ACC_WIDTH > 32) ? ACC_WIDTH : 32) + 1;
  localparam int DCW = $clog2(ACC_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, OUTPUT} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          bpf_q, bpf_d;
  logic [ACC_WIDTH-1:0] quot_q, quot_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [DCW-1:0]       div_cnt_q, div_cnt_d;
  logic [VAR_WIDTH-1:0] est_q, est_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;
  logic                 pend_q, pend_d;
  logic                 en_d_q, en_d_d;

  logic                 sample;
  logic [31:0]          bpf_in;
  logic [ACC_WIDTH:0]   sum;
  logic [RW-1:0]        rem_sh, divisor;
  logic                 rem_ge;
  logic                 go_div;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    bpf_d     = bpf_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    div_cnt_d = div_cnt_q;
    est_d     = est_q;
    valid_d   = valid_q;
    sat_d     = sat_q;
    pend_d    = pend_q;
    go_div    = 1'b0;

    en_d_d  = noise_mean_en;
    sample  = noise_mean_en & ~en_d_q;
    bpf_in  = (blocks_per_frame == 32'd0) ? 32'd1 : blocks_per_frame;
    sum     = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - VAR_WIDTH){1'b0}}, variance_in};
    rem_sh  = {rem_q[RW-2:0], acc_q[ACC_WIDTH-1]};
    divisor = RW'(cnt_q);
    rem_ge  = (rem_sh >= divisor);

    case (state_q)
      IDLE: begin
        if (start_of_frame || pend_q) begin
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          bpf_d   = bpf_in;
          pend_d  = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (start_of_frame) begin
          bpf_d = bpf_in;
          sat_d = 1'b0;
          if (sample) begin
            acc_d  = ACC_WIDTH'(variance_in);
            cnt_d  = 32'd1;
            go_div = (bpf_in == 32'd1);
          end else begin
            acc_d = '0;
            cnt_d = '0;
          end
        end else if (sample) begin
          acc_d  = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
          sat_d  = sat_q | sum[ACC_WIDTH];
          cnt_d  = cnt_q + 32'd1;
          go_div = ((cnt_q + 32'd1) == bpf_q);
        end
        if (go_div) begin
          rem_d     = '0;
          quot_d    = '0;
          div_cnt_d = '0;
          state_d   = DIVIDE;
        end
      end
      DIVIDE: begin
        pend_d    = pend_q | start_of_frame;
        rem_d     = rem_ge ? (rem_sh - divisor) : rem_sh;
        quot_d    = {quot_q[ACC_WIDTH-2:0], rem_ge};
        acc_d     = {acc_q[ACC_WIDTH-2:0], 1'b0};
        div_cnt_d = div_cnt_q + DCW'(1);
        if (div_cnt_q == DCW'(ACC_WIDTH - 1)) state_d = OUTPUT;
      end
      OUTPUT: begin
        pend_d = pend_q | start_of_frame;
        if (!valid_q) begin
          est_d   = (|quot_q[ACC_WIDTH-1:VAR_WIDTH]) ? {VAR_WIDTH{1'b1}} : quot_q[VAR_WIDTH-1:0];
          valid_d = 1'b1;
        end else if (out_if.noise_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      bpf_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      div_cnt_q <= '0;
      est_q     <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      pend_q    <= 1'b0;
      en_d_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      bpf_q     <= bpf_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      div_cnt_q <= div_cnt_d;
      est_q     <= est_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      pend_q    <= pend_d;
      en_d_q    <= en_d_d;
    end
  end

  assign out_if.noise_estimate = est_q;
  assign out_if.noise_valid    = valid_q;
  assign out_if.acc_saturated  = sat_q;
  assign busy                  = (state_q != IDLE);
endmodule
